out_channel_checker: RTL and testbench



---
 rtl/out_channel_checker.sv | 151 +++++++++++++++
 tb/tb_out_channel_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/out_channel_checker.sv
// Compares a stream of out-channel words against a preloaded table of expected values.
// LOAD fills the table, RUN drains a small FIFO one word per cycle, and DONE reports the verdict.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 2,
  parameter int Depth              = 4,
  parameter int MaxSteps           = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          out_valid_i,
  input  logic [MemoryElementWidth-1:0] out_data_i,
  output logic                          out_ready_o,
  input  logic                          halt_i,
  input  logic                          exp_write_i,
  input  logic [MemoryElementWidth-1:0] exp_data_i,
  input  logic                          start_i,
  output logic                          finished_o,
  output logic                          success_o,
  output logic [15:0]                   checked_o
);

  localparam int EAW = (NOut > 1) ? $clog2(NOut) : 1;
  localparam int ETW = $clog2(NOut + 1);
  localparam int FAW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int WDW = $clog2(MaxSteps + 1);

  localparam logic [ETW-1:0] EXP_FULL  = ETW'(NOut);
  localparam logic [ETW-1:0] EXP_ONE   = ETW'(1);
  localparam logic [FAW:0]   FPTR_ONE  = (FAW + 1)'(1);
  localparam logic [WDW-1:0] WD_LIMIT  = WDW'(MaxSteps);
  localparam logic [WDW-1:0] WD_ONE    = WDW'(1);
  localparam logic [15:0]    CHK_MAX   = 16'hFFFF;
  localparam logic [15:0]    CHK_ONE   = 16'h0001;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_e;

  state_e                        state_q, state_d;
  logic [MemoryElementWidth-1:0] exp_mem  [NOut];
  logic [MemoryElementWidth-1:0] fifo_mem [Depth];
  logic [ETW-1:0]                exp_top_q, exp_top_d;
  logic [FAW:0]                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]                   checked_q, checked_d;
  logic [WDW-1:0]                wdog_q, wdog_d;
  logic                          overflow_q, overflow_d;
  logic                          mismatch_q, mismatch_d;
  logic                          timeout_q, timeout_d;
  logic                          finished_q, finished_d;
  logic                          success_q, success_d;

  logic                          fifo_empty, fifo_full;
  logic                          push, pop, exp_wr_en, exp_hit;
  logic [MemoryElementWidth-1:0] pop_data, exp_word;

  // Extra MSB on the pointers separates the full case from the empty case.
  assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
  assign fifo_full   = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                       (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
  assign out_ready_o = (state_q == ST_RUN) && !fifo_full;
  assign push        = out_valid_i && out_ready_o;
  assign pop         = (state_q == ST_RUN) && !fifo_empty;
  assign exp_wr_en   = (state_q == ST_LOAD) && exp_write_i && (exp_top_q != EXP_FULL);
  assign pop_data    = fifo_mem[rd_ptr_q[FAW-1:0]];
  assign exp_hit     = (checked_q < 16'(exp_top_q));
  assign exp_word    = exp_mem[checked_q[EAW-1:0]];

  always_comb begin
    state_d    = state_q;
    exp_top_d  = exp_top_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    checked_d  = checked_q;
    wdog_d     = wdog_q;
    overflow_d = overflow_q;
    mismatch_d = mismatch_q;
    timeout_d  = timeout_q;
    finished_d = finished_q;
    success_d  = success_q;

    if (push) wr_ptr_d = wr_ptr_q + FPTR_ONE;

    unique case (state_q)
      ST_LOAD: begin
        if (exp_write_i) begin
          if (exp_top_q == EXP_FULL) overflow_d = 1'b1;
          else                       exp_top_d  = exp_top_q + EXP_ONE;
        end
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        wdog_d = wdog_q + WD_ONE;
        if (pop) begin
          rd_ptr_d = rd_ptr_q + FPTR_ONE;
          if (checked_q != CHK_MAX) checked_d = checked_q + CHK_ONE;
          // Words beyond the loaded table count as mismatches.
          if (!exp_hit || (pop_data != exp_word)) mismatch_d = 1'b1;
        end
        if (halt_i && fifo_empty && !push) state_d = ST_DONE;
        if (wdog_d == WD_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
        if (state_d == ST_DONE) begin
          finished_d = 1'b1;
          success_d  = !mismatch_d && !overflow_q && !timeout_d &&
                       (checked_d == 16'(exp_top_q));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_LOAD;
      exp_top_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      checked_q  <= '0;
      wdog_q     <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
      timeout_q  <= 1'b0;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_top_q  <= exp_top_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      checked_q  <= checked_d;
      wdog_q     <= wdog_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
      timeout_q  <= timeout_d;
      finished_q <= finished_d;
      success_q  <= success_d;
    end
  end

  // Storage arrays carry no reset; their contents are reloaded after every reset.
  always_ff @(posedge clk_i) begin
    if (exp_wr_en) exp_mem[exp_top_q[EAW-1:0]] <= exp_data_i;
    if (push)      fifo_mem[wr_ptr_q[FAW-1:0]] <= out_data_i;
  end

  assign finished_o = finished_q;
  assign success_o  = success_q;
  assign checked_o  = checked_q;

endmodule

// File: tb/tb_out_channel_checker.sv
// Randomized self-checking bench for out_channel_checker; expectations come from a
// queue-based model of the expected table and the pushed word stream.
module tb_out_channel_checker;

  localparam int W        = 12;
  localparam int NOUT     = 4;
  localparam int DEPTH    = 4;
  localparam int MAXSTEPS = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          out_valid = 1'b0;
  logic [W-1:0]  out_data = '0;
  logic          out_ready;
  logic          halt = 1'b0;
  logic          exp_write = 1'b0;
  logic [W-1:0]  exp_data = '0;
  logic          start = 1'b0;
  logic          finished;
  logic          success;
  logic [15:0]   checked;

  int n_cmp = 0;
  int n_err = 0;

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NOut(NOUT),
    .Depth(DEPTH),
    .MaxSteps(MAXSTEPS)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .out_valid_i(out_valid),
    .out_data_i(out_data),
    .out_ready_o(out_ready),
    .halt_i(halt),
    .exp_write_i(exp_write),
    .exp_data_i(exp_data),
    .start_i(start),
    .finished_o(finished),
    .success_o(success),
    .checked_o(checked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".finished"}, 32'(finished), 0);
    chk({tag, ".success"},  32'(success),  0);
    chk({tag, ".checked"},  32'(checked),  0);
    chk({tag, ".ready"},    32'(out_ready), 0);
  endtask

  task automatic do_reset(input string tag);
    out_valid = 1'b0;
    halt      = 1'b0;
    exp_write = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_cleared(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_table(input int nload, output logic [W-1:0] exp_vals[$], output bit ovf);
    logic [W-1:0] v;
    exp_vals = {};
    ovf = 1'b0;
    for (int i = 0; i < nload; i++) begin
      v = W'($urandom);
      exp_write = 1'b1;
      exp_data  = v;
      chk("load_ready", 32'(out_ready), 0);
      @(negedge clk);
      if (exp_vals.size() < NOUT) exp_vals.push_back(v);
      else                        ovf = 1'b1;
    end
    exp_write = 1'b0;
  endtask

  task automatic run_case(input string name, input int nload, input int npush,
                          input bit bad, input int gap_max);
    logic [W-1:0] exp_vals[$];
    logic [W-1:0] word;
    bit           ovf;
    bit           all_ok;
    bit           exp_succ;
    int           bad_idx;
    int           lat;

    all_ok  = 1'b1;
    bad_idx = -1;
    load_table(nload, exp_vals, ovf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (bad && npush > 0) bad_idx = $urandom_range(0, npush - 1);

    for (int i = 0; i < npush; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      if (i < exp_vals.size()) word = exp_vals[i];
      else                     word = W'($urandom);
      if (i == bad_idx) word = word ^ 12'h001;
      if (i >= exp_vals.size())    all_ok = 1'b0;
      else if (word != exp_vals[i]) all_ok = 1'b0;
      out_valid = 1'b1;
      out_data  = word;
      chk({name, ".ready"}, 32'(out_ready), 1);
      @(negedge clk);
      out_valid = 1'b0;
    end

    halt = 1'b1;
    lat  = 0;
    while (!finished && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    exp_succ = !ovf && all_ok && (npush == exp_vals.size());
    chk({name, ".latency"},  32'(lat), (npush > 0) ? 2 : 1);
    chk({name, ".finished"}, 32'(finished), 1);
    chk({name, ".success"},  32'(success), 32'(exp_succ));
    chk({name, ".checked"},  32'(checked), 32'(npush));
    chk({name, ".done_ready"}, 32'(out_ready), 0);

    exp_write = 1'b1;
    out_valid = 1'b1;
    @(negedge clk);
    exp_write = 1'b0;
    out_valid = 1'b0;
    chk({name, ".hold_finished"}, 32'(finished), 1);
    chk({name, ".hold_checked"},  32'(checked), 32'(npush));
    $display("case %s: load=%0d push=%0d bad=%0d -> checked=%0d success=%0d (model %0d)",
             name, nload, npush, bad, checked, success, exp_succ);
    do_reset({name, ".rst"});
  endtask

  task automatic watchdog_case();
    logic [W-1:0] exp_vals[$];
    bit ovf;
    int cyc;
    load_table(2, exp_vals, ovf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!finished && cyc < MAXSTEPS + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("wdog.cycle",    32'(cyc), MAXSTEPS + 1);
    chk("wdog.finished", 32'(finished), 1);
    chk("wdog.success",  32'(success), 0);
    $display("case watchdog: finished after %0d cycles, success=%0d", cyc, success);
    do_reset("wdog.rst");
  endtask

  task automatic midrun_reset_case();
    logic [W-1:0] exp_vals[$];
    bit ovf;
    load_table(2, exp_vals, ovf);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_valid = 1'b1;
    out_data  = exp_vals[0];
    @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    chk("midrun.checked_pre", 32'(checked), 1);
    chk("midrun.ready_pre",   32'(out_ready), 1);
    $display("case midrun_reset: checked=%0d before reset", checked);
    do_reset("midrun.rst");
  endtask

  initial begin
    #1 check_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_case("match2",   2, 2, 1'b0, 0);
    run_case("bad2",     2, 2, 1'b1, 0);
    run_case("extra",    1, 2, 1'b0, 0);
    run_case("burst6",   4, 6, 1'b0, 0);
    run_case("overflow", 5, 4, 1'b0, 0);
    run_case("empty",    0, 0, 1'b0, 0);
    watchdog_case();
    midrun_reset_case();
    for (int r = 0; r < 12; r++) begin
      run_case($sformatf("rand%0d", r), $urandom_range(0, 5), $urandom_range(0, 6),
               ($urandom_range(0, 2) == 0), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, got 1, expected 0");
    $fatal(1, "time limit");
  end

endmodule
